// File: rtl/vx_tc_tile_buf_pkg.sv
// Shared types for the tensor-core operand tile buffer: bank state machine,
// tile metadata layout and default geometry.
package vx_tc_tile_buf_pkg;

    localparam int TC_TILE_DIM = 4;
    localparam int TC_TAGW     = 8;
    localparam int TC_REPLAY_W = 2;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } tc_bank_state_e;

    typedef struct packed {
        logic [TC_TAGW-1:0]     tag;
        logic                   transpose;
        logic [TC_REPLAY_W-1:0] replay;
    } tc_tile_meta_t;

    function automatic logic tc_occupied(input tc_bank_state_e s);
        return (s != EMPTY);
    endfunction

    function automatic logic tc_writable(input tc_bank_state_e s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    function automatic logic tc_readable(input tc_bank_state_e s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/vx_tc_tile_buf_bank.sv
// One TILE_DIM x TILE_DIM tile bank: row-wide write port and a combinational
// read port returning either a row or a column of the stored tile.
module vx_tc_tile_buf_bank #(
    parameter int DATAW    = 32,
    parameter int TILE_DIM = 4
) (
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [$clog2(TILE_DIM)-1:0] row_i,
    input  logic [TILE_DIM*DATAW-1:0]   wdata_i,
    input  logic [$clog2(TILE_DIM)-1:0] idx_i,
    input  logic                        transpose_i,
    output logic [TILE_DIM*DATAW-1:0]   rdata_o
);

    logic [TILE_DIM-1:0][TILE_DIM-1:0][DATAW-1:0] mem_q;
    logic [TILE_DIM-1:0][DATAW-1:0]               rvec;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[row_i] <= wdata_i;
        end
    end

    // Column mode gathers element idx from every row.
    always_comb begin
        rvec = '0;
        for (int k = 0; k < TILE_DIM; k++) begin
            rvec[k] = transpose_i ? mem_q[k][idx_i] : mem_q[idx_i][k];
        end
    end

    assign rdata_o = rvec;

endmodule

// File: rtl/vx_tc_tile_buf.sv
// Multi-bank operand tile buffer: fills tiles row by row, then replays each
// tile to the PE group as rows or columns while the next bank fills.
module vx_tc_tile_buf
    import vx_tc_tile_buf_pkg::*;
#(
    parameter int DATAW    = 32,
    parameter int TILE_DIM = TC_TILE_DIM,
    parameter int NUM_BUFS = 2,
    parameter int REPLAY_W = TC_REPLAY_W,
    parameter int TAGW     = TC_TAGW
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        clear_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic [TILE_DIM*DATAW-1:0]   wr_data_i,
    input  logic                        wr_transpose_i,
    input  logic [REPLAY_W-1:0]         wr_replay_i,
    input  logic [TAGW-1:0]             wr_tag_i,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic [TILE_DIM*DATAW-1:0]   rd_data_o,
    output logic [$clog2(TILE_DIM)-1:0] rd_index_o,
    output logic [REPLAY_W-1:0]         rd_pass_o,
    output logic                        rd_last_o,
    output logic [TAGW-1:0]             rd_tag_o,
    output logic [$clog2(NUM_BUFS):0]   occupancy_o
);

    localparam int IW = $clog2(TILE_DIM);
    localparam int PW = $clog2(NUM_BUFS);
    localparam logic [IW-1:0] LAST_IDX = IW'(TILE_DIM - 1);

    typedef struct packed {
        logic [TAGW-1:0]     tag;
        logic                transpose;
        logic [REPLAY_W-1:0] replay;
    } meta_t;

    tc_bank_state_e state_q [NUM_BUFS];
    tc_bank_state_e state_d [NUM_BUFS];
    meta_t          meta_q  [NUM_BUFS];
    meta_t          rd_meta;

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]       wr_row_q, wr_row_d, rd_index_q, rd_index_d;
    logic [REPLAY_W-1:0] rd_pass_q, rd_pass_d;
    logic [PW:0]         occ_q, occ_d;
    logic                wr_fire, rd_fire, rd_last;

    logic [NUM_BUFS-1:0][TILE_DIM*DATAW-1:0] bank_rdata;

    assign rd_meta    = meta_q[rd_ptr_q];
    assign wr_ready_o = reset_i & tc_writable(state_q[wr_ptr_q]);
    assign rd_valid_o = reset_i & tc_readable(state_q[rd_ptr_q]);
    assign rd_last    = (rd_index_q == LAST_IDX) && (rd_pass_q == rd_meta.replay);
    assign rd_last_o  = rd_valid_o & rd_last;

    // A handshake that coincides with clear is dropped entirely.
    assign wr_fire = wr_valid_i & wr_ready_o & ~clear_i;
    assign rd_fire = rd_valid_o & rd_ready_i & ~clear_i;

    assign rd_data_o   = bank_rdata[rd_ptr_q];
    assign rd_index_o  = rd_index_q;
    assign rd_pass_o   = rd_pass_q;
    assign rd_tag_o    = rd_meta.tag;
    assign occupancy_o = reset_i ? occ_q : '0;

    for (genvar b = 0; b < NUM_BUFS; b++) begin : g_bank
        vx_tc_tile_buf_bank #(
            .DATAW    (DATAW),
            .TILE_DIM (TILE_DIM)
        ) u_bank (
            .clk_i       (clk_i),
            .we_i        (wr_fire && (wr_ptr_q == PW'(b))),
            .row_i       (wr_row_q),
            .wdata_i     (wr_data_i),
            .idx_i       (rd_index_q),
            .transpose_i (meta_q[b].transpose),
            .rdata_o     (bank_rdata[b])
        );
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire && (wr_row_q == '0)) begin
            meta_q[wr_ptr_q] <= '{tag: wr_tag_i, transpose: wr_transpose_i, replay: wr_replay_i};
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_row_d   = wr_row_q;
        rd_ptr_d   = rd_ptr_q;
        rd_index_d = rd_index_q;
        rd_pass_d  = rd_pass_q;

        // Write and read never target the same bank: one needs EMPTY/FILLING,
        // the other FULL/DRAINING.
        if (wr_fire) begin
            if (wr_row_q == LAST_IDX) begin
                state_d[wr_ptr_q] = FULL;
                wr_row_d          = '0;
                wr_ptr_d          = wr_ptr_q + PW'(1);
            end else begin
                state_d[wr_ptr_q] = FILLING;
                wr_row_d          = wr_row_q + IW'(1);
            end
        end

        if (rd_fire) begin
            if (rd_last) begin
                state_d[rd_ptr_q] = EMPTY;
                rd_index_d        = '0;
                rd_pass_d         = '0;
                rd_ptr_d          = rd_ptr_q + PW'(1);
            end else begin
                state_d[rd_ptr_q] = DRAINING;
                if (rd_index_q == LAST_IDX) begin
                    rd_index_d = '0;
                    rd_pass_d  = rd_pass_q + REPLAY_W'(1);
                end else begin
                    rd_index_d = rd_index_q + IW'(1);
                end
            end
        end

        if (clear_i) begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                state_d[b] = EMPTY;
            end
            wr_ptr_d   = '0;
            wr_row_d   = '0;
            rd_ptr_d   = '0;
            rd_index_d = '0;
            rd_pass_d  = '0;
        end

        occ_d = '0;
        for (int b = 0; b < NUM_BUFS; b++) begin
            if (tc_occupied(state_d[b])) begin
                occ_d = occ_d + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                state_q[b] <= EMPTY;
            end
            wr_ptr_q   <= '0;
            wr_row_q   <= '0;
            rd_ptr_q   <= '0;
            rd_index_q <= '0;
            rd_pass_q  <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_row_q   <= wr_row_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_index_q <= rd_index_d;
            rd_pass_q  <= rd_pass_d;
            occ_q      <= occ_d;
        end
    end

endmodule

// File: tb/tb_vx_tc_tile_buf.sv
// Self-checking bench for vx_tc_tile_buf: directed tiles plus a randomized
// backpressure run scored against a queue-of-tiles reference model.
module tb_vx_tc_tile_buf;

    localparam int DATAW  = 32;
    localparam int TD     = 4;
    localparam int NB     = 2;
    localparam int RW     = 2;
    localparam int TAGW   = 8;
    localparam int IW     = 2;
    localparam int OW     = 2;
    localparam int NTILES = 100;

    typedef logic [TD*DATAW-1:0] vec_t;
    typedef struct packed {
        logic [TD-1:0][TD*DATAW-1:0] rows;
        logic                        xp;
        logic [RW-1:0]               rep;
        logic [TAGW-1:0]             tag;
    } tile_t;

    logic            clk = 1'b0;
    logic            reset, clear, wr_valid, wr_ready, wr_transpose;
    logic            rd_valid, rd_ready, rd_last;
    vec_t            wr_data, rd_data;
    logic [RW-1:0]   wr_replay, rd_pass;
    logic [TAGW-1:0] wr_tag, rd_tag;
    logic [IW-1:0]   rd_index;
    logic [OW-1:0]   occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    vx_tc_tile_buf #(
        .DATAW(DATAW), .TILE_DIM(TD), .NUM_BUFS(NB), .REPLAY_W(RW), .TAGW(TAGW)
    ) dut (
        .clk_i(clk), .reset_i(reset), .clear_i(clear),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .wr_transpose_i(wr_transpose), .wr_replay_i(wr_replay), .wr_tag_i(wr_tag),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .rd_index_o(rd_index), .rd_pass_o(rd_pass), .rd_last_o(rd_last),
        .rd_tag_o(rd_tag), .occupancy_o(occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: completed tiles wait in a queue; mbeat walks the
    // front tile's (replay+1)*TD output vectors.
    tile_t mq[$];
    tile_t mpart;
    int    mrows = 0, mbeat = 0, m_in = 0, m_out = 0;

    function automatic bit m_wr_ready();
        return (mrows > 0) || (mq.size() < NB);
    endfunction

    function automatic bit m_rd_valid();
        return mq.size() > 0;
    endfunction

    function automatic int m_occ();
        return mq.size() + ((mrows > 0) ? 1 : 0);
    endfunction

    function automatic bit m_last();
        return mbeat == (int'(mq[0].rep) + 1) * TD - 1;
    endfunction

    function automatic vec_t m_vec();
        vec_t  v;
        tile_t t;
        int    i;
        t = mq[0];
        i = mbeat % TD;
        for (int k = 0; k < TD; k++)
            v[k*DATAW +: DATAW] = t.xp ? t.rows[k][i*DATAW +: DATAW] : t.rows[i][k*DATAW +: DATAW];
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < TD; k++) v[k*DATAW +: DATAW] = DATAW'($urandom);
        return v;
    endfunction

    // Advance one clock, updating the model from the pre-edge inputs.
    task automatic tick();
        bit              wf, rf, fl;
        vec_t            d;
        logic            xp;
        logic [RW-1:0]   rep;
        logic [TAGW-1:0] tag;
        fl  = !reset || clear;
        wf  = !fl && wr_valid && m_wr_ready();
        rf  = !fl && rd_ready && m_rd_valid();
        d   = wr_data;
        xp  = wr_transpose;
        rep = wr_replay;
        tag = wr_tag;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            mrows = 0;
            mbeat = 0;
        end else begin
            if (rf) begin
                if (m_last()) begin
                    void'(mq.pop_front());
                    mbeat = 0;
                    m_out++;
                end else begin
                    mbeat++;
                end
            end
            if (wf) begin
                if (mrows == 0) begin
                    mpart.xp  = xp;
                    mpart.rep = rep;
                    mpart.tag = tag;
                end
                mpart.rows[mrows] = d;
                mrows++;
                if (mrows == TD) begin
                    mq.push_back(mpart);
                    mrows = 0;
                    m_in++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 0; wr_valid = 1; rd_ready = 1; wr_data = rand_vec();
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || occupancy !== '0)
            $display("FAIL reset_hold: wr_ready=%b rd_valid=%b rd_last=%b occ=%0d, want 0 0 0 0",
                     wr_ready, rd_valid, rd_last, occupancy);
        else n_pass++;
        reset = 1; wr_valid = 0; rd_ready = 0;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || occupancy !== '0)
            $display("FAIL reset_release: wr_ready=%b rd_valid=%b occ=%0d, want 1 0 0",
                     wr_ready, rd_valid, occupancy);
        else n_pass++;
        tick();
    endtask

    task automatic test_tile(input bit xp, input int rep, input logic [TAGW-1:0] tag);
        vec_t exp_v;
        vec_t col0;
        int   nb, idx, pass;
        col0 = {32'd12, 32'd8, 32'd4, 32'd0};
        rd_ready = 1;
        for (int r = 0; r < TD; r++) begin
            wr_valid = 1;
            for (int e = 0; e < TD; e++) wr_data[e*DATAW +: DATAW] = DATAW'(TD*r + e);
            // Metadata on rows 1.. is junk and must be ignored.
            wr_transpose = (r == 0) ? xp : ~xp;
            wr_replay    = (r == 0) ? RW'(rep) : RW'($urandom);
            wr_tag       = (r == 0) ? tag : ~tag;
            @(negedge clk);
            n_checks++;
            if (wr_ready !== 1'b1 || rd_valid !== 1'b0)
                $display("FAIL tile_write r%0d: wr_ready=%b rd_valid=%b, want 1 0", r, wr_ready, rd_valid);
            else n_pass++;
            tick();
        end
        wr_valid = 0;
        wr_data  = rand_vec();
        nb = (rep + 1) * TD;
        for (int b = 0; b < nb; b++) begin
            idx  = b % TD;
            pass = b / TD;
            for (int e = 0; e < TD; e++)
                exp_v[e*DATAW +: DATAW] = xp ? DATAW'(TD*e + idx) : DATAW'(TD*idx + e);
            @(negedge clk);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v || rd_index !== IW'(idx) || rd_pass !== RW'(pass) ||
                rd_last !== logic'(b == nb - 1) || rd_tag !== tag || occupancy !== OW'(1))
                $display("FAIL tile_beat%0d: v=%b d=%h i=%0d p=%0d l=%b t=%h o=%0d, want 1 %h %0d %0d %b %h 1",
                         b, rd_valid, rd_data, rd_index, rd_pass, rd_last, rd_tag, occupancy,
                         exp_v, idx, pass, b == nb - 1, tag);
            else n_pass++;
            if (xp && b == 0) begin
                n_checks++;
                if (rd_data !== col0) $display("FAIL tile_col0: data=%h, want %h", rd_data, col0);
                else n_pass++;
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b0 || occupancy !== '0)
            $display("FAIL tile_done: rd_valid=%b occ=%0d, want 0 0", rd_valid, occupancy);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        rd_ready = 1; wr_transpose = 0; wr_replay = 0;
        for (int i = 0; i < 6*TD; i++) begin
            wr_valid = 1; wr_data = rand_vec(); wr_tag = TAGW'($urandom);
            @(negedge clk);
            n_checks++;
            if (wr_ready !== 1'b1 || rd_valid !== m_rd_valid())
                $display("FAIL b2b_stream%0d: wr_ready=%b rd_valid=%b, want 1 %b", i, wr_ready, rd_valid, m_rd_valid());
            else n_pass++;
            if (m_rd_valid()) begin
                n_checks++;
                if (rd_data !== m_vec() || rd_last !== m_last())
                    $display("FAIL b2b_data%0d: data=%h last=%b, want %h %b", i, rd_data, rd_last, m_vec(), m_last());
                else n_pass++;
            end
            tick();
        end
        wr_valid = 0;
        cyc = 0;
        while (m_rd_valid() && cyc < 100) begin
            @(negedge clk);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== m_vec() || rd_last !== m_last())
                $display("FAIL b2b_drain: v=%b data=%h last=%b, want 1 %h %b", rd_valid, rd_data, rd_last, m_vec(), m_last());
            else n_pass++;
            tick(); cyc++;
        end
        rd_ready = 0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1; wr_data = rand_vec(); wr_tag = TAGW'($urandom);
            @(negedge clk);
            n_checks++;
            if (wr_ready !== logic'(i < 2*TD))
                $display("FAIL b2b_stall_ready%0d: wr_ready=%b, want %b", i, wr_ready, i < 2*TD);
            else n_pass++;
            tick();
        end
        wr_valid = 0;
        @(negedge clk);
        n_checks++;
        if (occupancy !== OW'(2) || rd_valid !== 1'b1)
            $display("FAIL b2b_full: occ=%0d rd_valid=%b, want 2 1", occupancy, rd_valid);
        else n_pass++;
        tick();
        rd_ready = 1; cyc = 0;
        while (m_rd_valid() && cyc < 100) begin
            @(negedge clk);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== m_vec() || rd_tag !== mq[0].tag)
                $display("FAIL b2b_drain2: v=%b data=%h tag=%h, want 1 %h %h", rd_valid, rd_data, rd_tag, m_vec(), mq[0].tag);
            else n_pass++;
            tick(); cyc++;
        end
        rd_ready = 0;
    endtask

    task automatic test_backpressure();
        int              in0, out0, cyc;
        bit              stall;
        vec_t            pdata;
        logic [TAGW-1:0] ptag;
        in0 = m_in; out0 = m_out; cyc = 0; stall = 0;
        pdata = '0; ptag = '0;
        while ((m_out - out0) < NTILES && cyc < 20000) begin
            wr_valid     = ((m_in - in0) < NTILES) && ($urandom_range(0, 3) != 0);
            wr_data      = rand_vec();
            wr_transpose = 1'($urandom);
            wr_replay    = RW'($urandom);
            wr_tag       = TAGW'($urandom);
            rd_ready     = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if (wr_ready !== m_wr_ready() || rd_valid !== m_rd_valid() || occupancy !== OW'(m_occ()))
                $display("FAIL bp_ctrl c%0d: wr_ready=%b rd_valid=%b occ=%0d, want %b %b %0d",
                         cyc, wr_ready, rd_valid, occupancy, m_wr_ready(), m_rd_valid(), m_occ());
            else n_pass++;
            if (m_rd_valid()) begin
                n_checks++;
                if (rd_data !== m_vec() || rd_index !== IW'(mbeat % TD) || rd_pass !== RW'(mbeat / TD) ||
                    rd_last !== m_last() || rd_tag !== mq[0].tag)
                    $display("FAIL bp_data c%0d: d=%h i=%0d p=%0d l=%b t=%h, want %h %0d %0d %b %h",
                             cyc, rd_data, rd_index, rd_pass, rd_last, rd_tag,
                             m_vec(), mbeat % TD, mbeat / TD, m_last(), mq[0].tag);
                else n_pass++;
            end
            if (stall) begin
                n_checks++;
                if (rd_data !== pdata || rd_tag !== ptag)
                    $display("FAIL bp_stable c%0d: data=%h tag=%h, want %h %h", cyc, rd_data, rd_tag, pdata, ptag);
                else n_pass++;
            end
            stall = rd_valid && !rd_ready;
            pdata = rd_data;
            ptag  = rd_tag;
            tick();
            cyc++;
        end
        n_checks++;
        if ((m_out - out0) != NTILES)
            $display("FAIL bp_timeout: tiles drained=%0d, want %0d", m_out - out0, NTILES);
        else n_pass++;
        wr_valid = 0; rd_ready = 0;
    endtask

    task automatic test_flush(input bit use_reset);
        int cyc;
        rd_ready = 0; wr_transpose = 0; wr_replay = 0;
        for (int i = 0; i < TD + 2; i++) begin
            wr_valid = 1; wr_data = rand_vec(); wr_tag = TAGW'($urandom);
            tick();
        end
        wr_valid = 1; rd_ready = 1; wr_data = rand_vec();
        if (use_reset) reset = 0;
        else           clear = 1;
        @(negedge clk);
        n_checks++;
        if (use_reset ? (wr_ready !== 1'b0 || rd_valid !== 1'b0 || occupancy !== '0)
                      : (wr_ready !== 1'b1 || rd_valid !== 1'b1 || occupancy !== OW'(2)))
            $display("FAIL flush_cycle rst=%0d: wr_ready=%b rd_valid=%b occ=%0d", use_reset, wr_ready, rd_valid, occupancy);
        else n_pass++;
        tick();
        reset = 1; clear = 0; wr_valid = 0; rd_ready = 0;
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b0 || occupancy !== '0 || wr_ready !== 1'b1)
            $display("FAIL flush_after rst=%0d: rd_valid=%b occ=%0d wr_ready=%b, want 0 0 1",
                     use_reset, rd_valid, occupancy, wr_ready);
        else n_pass++;
        tick();
        wr_transpose = 1; wr_replay = 1; wr_tag = TAGW'($urandom);
        for (int r = 0; r < TD; r++) begin
            wr_valid = 1; wr_data = rand_vec();
            tick();
        end
        wr_valid = 0; rd_ready = 1; cyc = 0;
        n_checks++;
        if (mq.size() != 1) $display("FAIL flush_refill: model tiles=%0d, want 1", mq.size());
        else n_pass++;
        while (m_rd_valid() && cyc < 100) begin
            @(negedge clk);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== m_vec() || rd_last !== m_last() || rd_tag !== mq[0].tag)
                $display("FAIL flush_read rst=%0d: v=%b d=%h l=%b t=%h, want 1 %h %b %h",
                         use_reset, rd_valid, rd_data, rd_last, rd_tag, m_vec(), m_last(), mq[0].tag);
            else n_pass++;
            tick(); cyc++;
        end
        rd_ready = 0;
    endtask

    initial begin
        reset = 0; clear = 0; wr_valid = 0; rd_ready = 0;
        wr_data = '0; wr_transpose = 0; wr_replay = '0; wr_tag = '0;
        test_reset();
        test_tile(1'b0, 0, 8'h5A);
        test_tile(1'b1, 0, 8'hC3);
        test_tile(1'b0, 2, 8'h11);
        test_back_to_back();
        test_backpressure();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
